// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared states, register offsets and CTRL field positions for timer_counter
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT    = 2'd0;
    localparam logic [1:0] MODE_AUTORELOAD = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counter with maskable IRQ; auto-reload mode enabled by TC_AUTORELOAD_EN
module timer_counter
    import tc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;
    tc_state_e   state_q;

    logic        ctrl_we;
    logic        preset_we;
    logic        reload_mode;
    logic [1:0]  mode;
    logic        unused_addr;

    assign ctrl_we   = WE && (Addr[3:2] == OFF_CTRL);
    assign preset_we = WE && (Addr[3:2] == OFF_PRESET);
    assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

`ifdef TC_AUTORELOAD_EN
    assign reload_mode = (mode == MODE_AUTORELOAD);
`else
    // Mode bits are still stored and read back, but every code runs one-shot.
    assign reload_mode = 1'b0;
`endif

    // Only the word offset is decoded; the window hit is already folded into WE.
    assign unused_addr = ^{Addr[31:4], Addr[1:0], mode};

    // Counting FSM plus register file; CPU writes are placed last so they win over FSM updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_q[CTRL_EN]) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_q <= preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[CTRL_EN]) begin
                        state_q <= ST_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // A preset of 0 or 1 lands here on the first CNT cycle, never wrapping.
                        count_q    <= 32'd0;
                        irq_flag_q <= 1'b1;
                        state_q    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (reload_mode) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= ST_LOAD;
                    end else begin
                        ctrl_q[CTRL_EN] <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (ctrl_we) begin
                ctrl_q     <= Din[3:0];
                irq_flag_q <= 1'b0;
            end
            if (preset_we) begin
                preset_q   <= Din;
                irq_flag_q <= 1'b0;
            end
        end
    end

    // Zero-wait-state read mux; unused offsets read as zero.
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            OFF_CTRL:   Dout = {28'd0, ctrl_q};
            OFF_PRESET: Dout = preset_q;
            OFF_COUNT:  Dout = count_q;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter register map, count timing and IRQ behaviour
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int total;
    int bad;

    logic [31:0] exp_q [$];

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push the expectation, present the address, pop and compare once Dout settles.
    task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
        exp_q.push_back(exp);
        Addr = 32'h7f00 | {28'd0, off, 2'b00};
        #1;
        check(tag, Dout, exp_q.pop_front());
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        exp_q.push_back({31'd0, exp});
        check(tag, {31'd0, IRQ}, exp_q.pop_front());
    endtask

    // Called at a negative edge; the write lands on the following rising edge.
    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        Addr = 32'h7f00 | {28'd0, off, 2'b00};
        Din  = data;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    // Expected COUNT k edges after the enabling write, starting from count 'prev'.
    function automatic logic [31:0] cnt_model(input int k, input int p, input logic [31:0] prev);
        int pe;
        pe = (p < 1) ? 1 : p;
        if (k < 2) return prev;
        if (k - 2 >= pe) return 32'd0;
        return p - (k - 2);
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        Addr  = 32'h7f00;
        WE    = 1'b0;
        Din   = 32'd0;

        repeat (2) @(negedge clk);
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_preset", 2'd1, 32'd0);
        rd("rst_count", 2'd2, 32'd0);
        rd("rst_off3", 2'd3, 32'd0);
        irq_chk("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // One-shot, IM set, preset 5
        wr(2'd1, 32'd5);
        rd("os_preset", 2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 0; k <= 10; k++) begin
            rd($sformatf("os_count_k%0d", k), 2'd2, cnt_model(k, 5, 32'd0));
            irq_chk($sformatf("os_irq_k%0d", k), k >= 7);
            @(negedge clk);
        end
        rd("os_ctrl_after", 2'd0, 32'h8);
        irq_chk("os_irq_sticky", 1'b1);
        wr(2'd1, 32'd3);
        irq_chk("os_irq_cleared", 1'b0);

        // Mode 1 with IM: periodic pulses when auto-reload is built in, sticky otherwise
        wr(2'd0, 32'hB);
        for (int k = 0; k <= 17; k++) begin
`ifdef TC_AUTORELOAD_EN
            irq_chk($sformatf("ar_irq_k%0d", k), (k >= 5) && ((k - 5) % 5 == 0));
`else
            irq_chk($sformatf("ar_irq_k%0d", k), k >= 5);
`endif
            if (k == 3) rd("ar_ctrl", 2'd0, 32'hB);
            if (k == 4) rd("ar_count", 2'd2, 32'd1);
            @(negedge clk);
        end
`ifdef TC_AUTORELOAD_EN
        rd("ar_ctrl_end", 2'd0, 32'hB);
`else
        rd("ar_ctrl_end", 2'd0, 32'hA);
`endif
        wr(2'd0, 32'h0);
        repeat (3) @(negedge clk);
        irq_chk("ar_irq_off", 1'b0);

        // Masked interrupt: count completes silently
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        for (int k = 0; k <= 14; k++) begin
            irq_chk($sformatf("mask_irq_k%0d", k), 1'b0);
            @(negedge clk);
        end
        rd("mask_count", 2'd2, 32'd0);
        rd("mask_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h9);
        irq_chk("mask_unmask_irq", 1'b0);
        wr(2'd0, 32'h0);
        repeat (3) @(negedge clk);

        // Disable mid-count, then re-enable
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        repeat (9) @(negedge clk);
        rd("mid_count13", 2'd2, 32'd13);
        wr(2'd0, 32'h0);
        rd("mid_count12", 2'd2, 32'd12);
        repeat (4) @(negedge clk);
        rd("mid_hold12", 2'd2, 32'd12);
        wr(2'd0, 32'h9);
        @(negedge clk);
        rd("mid_reload_load", 2'd2, 32'd12);
        @(negedge clk);
        rd("mid_reload20", 2'd2, 32'd20);
        repeat (3) @(negedge clk);
        rd("mid_count17", 2'd2, 32'd17);

        // Asynchronous reset mid-count
        reset = 1'b1;
        rd("arst_ctrl", 2'd0, 32'd0);
        rd("arst_preset", 2'd1, 32'd0);
        rd("arst_count", 2'd2, 32'd0);
        irq_chk("arst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Read-only and reserved offsets ignore writes; CTRL keeps only 4 bits
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd("ro_count", 2'd2, 32'd0);
        rd("ro_off3", 2'd3, 32'd0);
        rd("ro_preset", 2'd1, 32'd0);
        rd("ro_ctrl", 2'd0, 32'd0);
        wr(2'd0, 32'hFFFF_FFFF);
        rd("ctrl_mask", 2'd0, 32'hF);
        irq_chk("p0_irq_k0", 1'b0);
        @(negedge clk);
        @(negedge clk);
        irq_chk("p0_irq_k2", 1'b0);
        @(negedge clk);
        irq_chk("p0_irq_k3", 1'b1);
        rd("p0_count", 2'd2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter that responds to CPU load/store traffic routed to one timer window (e.g. 0x7f00–0x7f0b or 0x7f10–0x7f1b). It decodes a word offset, exposes CTRL/PRESET/COUNT registers, runs a four-state counting FSM, and raises a maskable interrupt request toward the CPU. Two instances sit beside the data memory on the system bus.

## Interface
Parameters:
- none; register width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  32  byte address from the bus; only Addr[3:2] is decoded.
- WE  input  1  write enable, already qualified by the address-window hit.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr[3:2].
- IRQ  output  1  interrupt request, level.

One clock; reset is asynchronous and active-high.

## Operation
- Offset 0 is CTRL. Only bits [3:0] are stored; all other bits read 0. Bit [0] is Enable. Bits [2:1] are Mode: 0 = one-shot, 1 = auto-reload, 2/3 = one-shot. Bit [3] is IM, the interrupt mask; 1 = unmasked.
- Offset 1 is PRESET, read/write, 32 bits.
- Offset 2 is COUNT, read-only; writes are ignored.
- Offset 3 reads 0; writes are ignored.
- FSM states are IDLE, LOAD, CNT and INT.
  - IDLE: if Enable=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if Enable=0, go to IDLE and hold COUNT. Otherwise, if COUNT>1, COUNT <= COUNT−1. Otherwise (COUNT ≤ 1), COUNT <= 0, irq_flag <= 1, go to INT.
  - INT in one-shot mode: Enable <= 0, go to IDLE. irq_flag stays set.
  - INT in auto-reload mode: irq_flag <= 0, go to LOAD.
- IRQ = IM & irq_flag.
- A write to CTRL or PRESET clears irq_flag.
- If a CPU write to CTRL and an FSM write to Enable (from INT) happen in the same cycle, the CPU write wins.
- A PRESET write does not alter a count in progress; it takes effect at the next LOAD.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, IRQ=0. Dout reads 0 for every offset.
- Reset asserted mid-count forces the reset values immediately. There is no pending interrupt after reset.
- Enable write at edge t gives: LOAD at t+1, CNT with COUNT=P at t+2, INT at t+2+max(P,1). IRQ rises at that same edge when IM=1.
- P=0 and P=1 behave identically: INT is reached at t+3.
- Auto-reload: INT at edge e, then LOAD at e+1, CNT at e+2, next INT at e+2+max(P,1). The period is max(P,1)+2 cycles. IRQ is high for exactly one cycle per period.
- One-shot: IRQ stays high until a CTRL or PRESET write, or until IM is cleared.
- Clearing Enable during CNT: IDLE at the next edge. COUNT is frozen, and re-enabling reloads from PRESET.
- Dout is valid in the same cycle as Addr, with no wait states. A register written at edge t reads its new value after t.

## Configuration
- TC_AUTORELOAD_EN defined: Mode 1 behaves as auto-reload, as described above.
- Not defined: every Mode value behaves as one-shot. The Mode bits are still stored and read back.

## Structure
- Package tc_pkg holds:
  - the state enum (IDLE, LOAD, CNT, INT);
  - offset constants (CTRL=2'd0, PRESET=2'd1, COUNT=2'd2);
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode codes (ONESHOT=2'd0, AUTORELOAD=2'd1).
- Single module with no sub-module. The register file, FSM and read mux are small enough to stay flat.

## Test plan
- Reset then read offsets 0/1/2/3 → all return 0; IRQ=0.
- PRESET=5, CTRL=0x9 (enable, one-shot, IM) → COUNT reads 5,4,3,2,1,0. IRQ rises 7 cycles after the CTRL write edge and stays high. CTRL then reads 0x8. A PRESET write drops IRQ.
- PRESET=3, CTRL=0xB with TC_AUTORELOAD_EN → IRQ pulses one cycle every 5 cycles, repeated at least 3 times. Without the macro, a single sticky IRQ.
- PRESET=10, CTRL=0x1 (IM=0) → the count completes with IRQ=0 throughout. A subsequent CTRL write of 0x9 leaves IRQ=0, because irq_flag was cleared by that write.
- Mid-count: PRESET=20, enable, write CTRL=0x0 when COUNT=12 → COUNT holds 12. Re-enabling reloads 20. Assert reset mid-count → all registers 0 and IRQ=0 immediately.
- Write 0xFFFF_FFFF to COUNT and to offset 3 → no effect. CTRL=0xFFFF_FFFF reads back 0xF.
